// File: rtl/player_command_scheduler_pkg.sv
// Shared command encodings and helpers for the player command scheduler.
package player_command_scheduler_pkg;

    localparam int unsigned CMD_W = 6;

    typedef logic [CMD_W-1:0] cmd_t;

    localparam cmd_t CMD_MOVE_RIGHT = 6'b100000;
    localparam cmd_t CMD_MOVE_LEFT  = 6'b010000;
    localparam cmd_t CMD_WAIT       = 6'b001000;
    localparam cmd_t CMD_JUMP       = 6'b000100;
    localparam cmd_t CMD_KICK       = 6'b000010;
    localparam cmd_t CMD_PUNCH      = 6'b000001;

    // True when exactly one bit of the command is set.
    function automatic logic is_onehot(input cmd_t c);
        return (c != '0) && ((c & (c - cmd_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/player_command_scheduler_cmd_fifo.sv
// Single-clock command FIFO with occupancy level and synchronous flush.
module cmd_fifo
    import player_command_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = CMD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LVL_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/player_command_scheduler.sv
// Buffers per-player action requests and issues one command per player per game tick.
module player_command_scheduler
    import player_command_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     tick,
    input  logic                     flush,
    input  logic                     left_req_valid,
    input  logic [CMD_W-1:0]         left_req_code,
    output logic                     left_req_ready,
    input  logic                     right_req_valid,
    input  logic [CMD_W-1:0]         right_req_code,
    output logic                     right_req_ready,
    output logic [CMD_W-1:0]         left_cmd_out,
    output logic [CMD_W-1:0]         right_cmd_out,
    output logic [$clog2(DEPTH):0]   left_level,
    output logic [$clog2(DEPTH):0]   right_level,
    output logic [DROP_W-1:0]        left_drop_cnt,
    output logic [DROP_W-1:0]        right_drop_cnt
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    // Index 0 is the left player, index 1 the right player.
    logic [1:0]            req_valid;
    logic [1:0][CMD_W-1:0] req_code;

    assign req_valid = {right_req_valid, left_req_valid};
    assign req_code  = {right_req_code, left_req_code};

    for (genvar s = 0; s < 2; s++) begin : g_side
        logic             code_ok;
        logic             push;
        logic             reject;
        logic             pop;
        logic             full;
        logic             empty;
        logic [CMD_W-1:0] head;
        logic [LVL_W-1:0] level;
        logic [CMD_W-1:0] cmd_q;
        logic [DROP_W-1:0] drop_q;

        // Ready comes from the registered level only, so a full FIFO refuses even on a tick.
        assign code_ok = is_onehot(req_code[s]);
        assign push    = req_valid[s] & ~full & code_ok & ~flush;
        assign reject  = req_valid[s] & ~full & ~code_ok & ~flush;
        assign pop     = tick & ~empty & ~flush;

        cmd_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (CMD_W)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .flush (flush),
            .push  (push),
            .wdata (req_code[s]),
            .pop   (pop),
            .rdata (head),
            .level (level),
            .full  (full),
            .empty (empty)
        );

        // Command register: advances only on tick, WAIT when nothing is queued or on flush.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cmd_q <= CMD_WAIT;
            end else if (flush) begin
                cmd_q <= CMD_WAIT;
            end else if (tick) begin
                cmd_q <= empty ? CMD_WAIT : head;
            end
        end

        // Saturating count of malformed requests that were offered while ready.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                drop_q <= '0;
            end else if (reject && (drop_q != '1)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    assign left_req_ready  = ~g_side[0].full;
    assign right_req_ready = ~g_side[1].full;
    assign left_cmd_out    = g_side[0].cmd_q;
    assign right_cmd_out   = g_side[1].cmd_q;
    assign left_level      = g_side[0].level;
    assign right_level     = g_side[1].level;
    assign left_drop_cnt   = g_side[0].drop_q;
    assign right_drop_cnt  = g_side[1].drop_q;

endmodule

// File: tb/tb_player_command_scheduler.sv
// Directed self-checking bench for player_command_scheduler (DEPTH=4, DROP_W=8).
module tb_player_command_scheduler;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DROP_W = 8;

    localparam logic [5:0] MR = 6'b100000;
    localparam logic [5:0] ML = 6'b010000;
    localparam logic [5:0] WT = 6'b001000;
    localparam logic [5:0] JP = 6'b000100;
    localparam logic [5:0] KK = 6'b000010;
    localparam logic [5:0] PN = 6'b000001;

    logic              clk;
    logic              rst_n;
    logic              tick;
    logic              flush;
    logic              left_req_valid;
    logic [5:0]        left_req_code;
    logic              left_req_ready;
    logic              right_req_valid;
    logic [5:0]        right_req_code;
    logic              right_req_ready;
    logic [5:0]        left_cmd_out;
    logic [5:0]        right_cmd_out;
    logic [2:0]        left_level;
    logic [2:0]        right_level;
    logic [7:0]        left_drop_cnt;
    logic [7:0]        right_drop_cnt;

    int unsigned n_cmp;
    int unsigned n_err;

    player_command_scheduler #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick            (tick),
        .flush           (flush),
        .left_req_valid  (left_req_valid),
        .left_req_code   (left_req_code),
        .left_req_ready  (left_req_ready),
        .right_req_valid (right_req_valid),
        .right_req_code  (right_req_code),
        .right_req_ready (right_req_ready),
        .left_cmd_out    (left_cmd_out),
        .right_cmd_out   (right_cmd_out),
        .left_level      (left_level),
        .right_level     (right_level),
        .left_drop_cnt   (left_drop_cnt),
        .right_drop_cnt  (right_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are applied 1ns after a rising edge and sampled at the next one.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick            = 1'b0;
        flush           = 1'b0;
        left_req_valid  = 1'b0;
        left_req_code   = '0;
        right_req_valid = 1'b0;
        right_req_code  = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_lcmd"}, 32'(left_cmd_out), 32'(WT));
        check({tag, "_rcmd"}, 32'(right_cmd_out), 32'(WT));
        check({tag, "_llvl"}, 32'(left_level), 0);
        check({tag, "_rlvl"}, 32'(right_level), 0);
        check({tag, "_lrdy"}, 32'(left_req_ready), 1);
        check({tag, "_rrdy"}, 32'(right_req_ready), 1);
        check({tag, "_ldrp"}, 32'(left_drop_cnt), 0);
        check({tag, "_rdrp"}, 32'(right_drop_cnt), 0);
    endtask

    logic [5:0] l_seq [3];
    logic [5:0] r_seq [3];
    logic [5:0] l_exp [4];
    logic [5:0] r_exp [4];
    logic [5:0] fill  [5];

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle();
        rst_n = 1'b0;
        #12;
        check_reset_state("rst");
        rst_n = 1'b1;
        step();

        // Ticks with nothing queued give WAIT.
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            step();
            check($sformatf("idle_tick%0d_lcmd", i), 32'(left_cmd_out), 32'(WT));
            check($sformatf("idle_tick%0d_rcmd", i), 32'(right_cmd_out), 32'(WT));
            check($sformatf("idle_tick%0d_llvl", i), 32'(left_level), 0);
            check($sformatf("idle_tick%0d_lrdy", i), 32'(left_req_ready), 1);
        end
        idle();

        // In-order issue on both sides.
        l_seq = '{MR, MR, KK};
        r_seq = '{ML, ML, PN};
        l_exp = '{MR, MR, KK, WT};
        r_exp = '{ML, ML, PN, WT};
        for (int i = 0; i < 3; i++) begin
            left_req_valid  = 1'b1;
            left_req_code   = l_seq[i];
            right_req_valid = 1'b1;
            right_req_code  = r_seq[i];
            step();
        end
        idle();
        check("seq_llvl", 32'(left_level), 3);
        check("seq_rlvl", 32'(right_level), 3);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            step();
            check($sformatf("seq_tick%0d_lcmd", i), 32'(left_cmd_out), 32'(l_exp[i]));
            check($sformatf("seq_tick%0d_rcmd", i), 32'(right_cmd_out), 32'(r_exp[i]));
        end
        idle();
        step();
        check("seq_hold_lcmd", 32'(left_cmd_out), 32'(WT));

        // Fill past capacity; the fifth request is refused and not counted.
        fill = '{PN, KK, JP, ML, MR};
        for (int i = 0; i < 5; i++) begin
            left_req_valid = 1'b1;
            left_req_code  = fill[i];
            step();
            if (i == 3) begin
                check("full_rdy", 32'(left_req_ready), 0);
                check("full_lvl", 32'(left_level), 4);
            end
        end
        check("over_lvl", 32'(left_level), 4);
        check("over_drop", 32'(left_drop_cnt), 0);
        check("over_rdy", 32'(left_req_ready), 0);
        idle();
        tick = 1'b1;
        step();
        check("pop_rdy", 32'(left_req_ready), 1);
        check("pop_lvl", 32'(left_level), 3);
        check("pop_cmd", 32'(left_cmd_out), 32'(PN));
        for (int i = 1; i < 5; i++) begin
            step();
            check($sformatf("drain%0d_cmd", i), 32'(left_cmd_out), 32'((i < 4) ? fill[i] : WT));
        end
        idle();

        // Malformed codes are counted, never stored, and the count saturates.
        right_req_valid = 1'b1;
        right_req_code  = 6'b000011;
        step();
        right_req_code  = 6'b000000;
        step();
        idle();
        check("inv_drop", 32'(right_drop_cnt), 2);
        check("inv_lvl", 32'(right_level), 0);
        check("inv_rdy", 32'(right_req_ready), 1);
        check("inv_ldrop", 32'(left_drop_cnt), 0);
        right_req_valid = 1'b1;
        right_req_code  = 6'b110000;
        for (int i = 0; i < 252; i++) step();
        idle();
        check("inv_254", 32'(right_drop_cnt), 254);
        right_req_valid = 1'b1;
        right_req_code  = 6'b111111;
        for (int i = 0; i < 50; i++) step();
        idle();
        check("inv_sat", 32'(right_drop_cnt), 255);
        check("inv_sat_lvl", 32'(right_level), 0);

        // No bypass: push on the tick cycle of an empty FIFO issues on the next tick.
        tick           = 1'b1;
        left_req_valid = 1'b1;
        left_req_code  = JP;
        step();
        idle();
        check("nobyp_cmd", 32'(left_cmd_out), 32'(WT));
        check("nobyp_lvl", 32'(left_level), 1);
        tick = 1'b1;
        step();
        idle();
        check("nobyp_next_cmd", 32'(left_cmd_out), 32'(JP));
        check("nobyp_next_lvl", 32'(left_level), 0);

        // Flush beats tick and push.
        for (int i = 0; i < 3; i++) begin
            left_req_valid  = 1'b1;
            left_req_code   = KK;
            right_req_valid = 1'b1;
            right_req_code  = MR;
            step();
        end
        idle();
        check("fl_pre_llvl", 32'(left_level), 3);
        flush           = 1'b1;
        tick            = 1'b1;
        left_req_valid  = 1'b1;
        left_req_code   = MR;
        right_req_valid = 1'b1;
        right_req_code  = PN;
        step();
        idle();
        check("fl_llvl", 32'(left_level), 0);
        check("fl_rlvl", 32'(right_level), 0);
        check("fl_lcmd", 32'(left_cmd_out), 32'(WT));
        check("fl_rcmd", 32'(right_cmd_out), 32'(WT));
        check("fl_rdrop", 32'(right_drop_cnt), 255);
        tick = 1'b1;
        step();
        idle();
        check("fl_next_lcmd", 32'(left_cmd_out), 32'(WT));
        check("fl_next_rcmd", 32'(right_cmd_out), 32'(WT));
        check("fl_next_llvl", 32'(left_level), 0);

        // Asynchronous reset mid-queue.
        for (int i = 0; i < 2; i++) begin
            left_req_valid  = 1'b1;
            left_req_code   = ML;
            right_req_valid = 1'b1;
            right_req_code  = JP;
            step();
        end
        idle();
        tick = 1'b1;
        step();
        idle();
        check("ar_pre_lcmd", 32'(left_cmd_out), 32'(ML));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("ar");
        #1;
        rst_n = 1'b1;
        tick = 1'b1;
        step();
        idle();
        check("ar_post_lcmd", 32'(left_cmd_out), 32'(WT));
        check("ar_post_rcmd", 32'(right_cmd_out), 32'(WT));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/player_command_scheduler.md
Name: player_command_scheduler

Overview:
- Upstream feeder for the fighting-game core.
- Accepts asynchronous-rate action requests from two players, buffers them per player in small FIFOs, and issues exactly one one-hot 6-bit command per player on each game tick.
- Its outputs drive the core's left/right player input buses directly. WAIT is substituted whenever a player has nothing queued.

Parameters:
- DEPTH, 4, entries per player FIFO (power of two, ≥2).
- DROP_W, 8, width of the saturating invalid-request counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle game-step strobe; commands advance only on this cycle
- flush  input  1  synchronous clear of both queues (round end / game over)
- left_req_valid  input  1  left player request present
- left_req_code  input  6  left request, one-hot: [5]MOVE_RIGHT [4]MOVE_LEFT [3]WAIT [2]JUMP [1]KICK [0]PUNCH
- left_req_ready  output  1  left FIFO can accept
- right_req_valid  input  1  right player request present
- right_req_code  input  6  right request, same encoding
- right_req_ready  output  1  right FIFO can accept
- left_cmd_out  output  6  registered command to core, left player
- right_cmd_out  output  6  registered command to core, right player
- left_level  output  $clog2(DEPTH)+1  left FIFO occupancy
- right_level  output  $clog2(DEPTH)+1  right FIFO occupancy
- left_drop_cnt  output  DROP_W  saturating count of rejected left requests
- right_drop_cnt  output  DROP_W  saturating count of rejected right requests

Behaviour:
- Reset values (async, rst_n=0): cmd_out = 6'b001000 (WAIT) on both sides; levels 0; drop counters 0; ready = 1; FIFO pointers 0.
- Players are fully independent. Both sides use identical logic.
- Push: a request is accepted when valid & ready & code is exactly one-hot. The accepted code is written at the tail and the level increments next cycle.
- ready = !full. It is derived from registered level only, with no same-cycle pop look-ahead, so a push is rejected when level == DEPTH even on a tick cycle.
- Invalid code (zero bits or more than one bit set) with valid & ready:
  - Not stored; ready stays unchanged.
  - drop_cnt increments, saturating at 2^DROP_W-1.
- Valid while not ready: the request is not stored and is not counted. The requester must hold it.
- Tick:
  - If level > 0, cmd_out <= head and the entry is popped.
  - If level == 0, cmd_out <= WAIT.
  - cmd_out is held unchanged on all non-tick cycles. Latency from accept to output is at least the next tick after the cycle of acceptance.
- No bypass: a push and a tick in the same cycle on an empty FIFO yields cmd_out = WAIT. The entry is stored (level becomes 1) and issues on the following tick.
- Push and pop in the same cycle with 0 < level < DEPTH: level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Level distinguishes full from empty.
- flush (synchronous, highest priority over push/pop/tick):
  - Both FIFOs emptied; both cmd_out <= WAIT.
  - Same-cycle requests are discarded and not counted.
  - drop counters retained.
- Reset mid-operation: all state returns immediately to reset values; queued entries are lost.

Decomposition:
- Shared package holds:
  - command encodings CMD_MOVE_RIGHT, CMD_MOVE_LEFT, CMD_WAIT, CMD_JUMP, CMD_KICK, CMD_PUNCH (6-bit one-hot);
  - CMD_W = 6;
  - an is_onehot function.
- Natural sub-module: cmd_fifo, a parameterised single-clock FIFO with:
  - push and pop;
  - level, full and empty;
  - synchronous flush.
  It is instantiated once per player. The top level holds validation, drop counters and the cmd_out registers.

Test Plan:
- Reset then 3 ticks with no requests -> both cmd_out = 6'b001000 every tick; levels 0; ready = 1.
- Left pushes MOVE_RIGHT, MOVE_RIGHT, KICK on consecutive non-tick cycles; right pushes MOVE_LEFT ×2, then PUNCH. Apply 4 ticks:
  - left_cmd_out = 100000, 100000, 000010, 001000;
  - right_cmd_out = 010000, 010000, 000001, 001000.
- Push 5 requests to left with DEPTH=4 and no tick:
  - ready drops after the 4th; left_level = 4;
  - the 5th is not stored; left_drop_cnt stays 0.
  - Then one tick -> ready = 1, level = 3.
- Right pushes 6'b000011 and 6'b000000 -> right_drop_cnt = 2, right_level = 0. Pushing 256+ invalids -> counter saturates at 255.
- Push JUMP in the same cycle as tick on an empty left FIFO -> left_cmd_out = WAIT on that tick; left_level = 1; next tick gives 000100.
- Queue 3 entries per side, assert flush together with a tick and a push:
  - both levels 0; both cmd_out = WAIT;
  - the same-cycle push is discarded;
  - the next tick outputs WAIT.
- Assert rst_n low mid-queue -> all outputs return to reset values asynchronously.
